// File: rtl/wb_regfile_scoreboard_if.sv
// Bus bundle between the MEM/WB + ID control logic (master) and the
// register file / scoreboard (slave).
interface wb_regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] wb_dreg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_use;
  logic              rt_use;
  logic              iss_we;
  logic [ADDR_W-1:0] iss_dreg;
  logic              cancel_we;
  logic [ADDR_W-1:0] cancel_dreg;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              stall;
  logic              sb_err;

  // Handshake: no valid/ready pair here. wb_we, iss_we and cancel_we are
  // single-cycle strobes sampled at posedge. iss_we only counts when stall
  // is low in that same cycle; stall is combinational from the current inputs.
  modport master (
    output wb_dreg, wb_data, wb_we, rs_addr, rt_addr, rs_use, rt_use,
           iss_we, iss_dreg, cancel_we, cancel_dreg,
    input  rs_data, rt_data, stall, sb_err
  );

  modport slave (
    input  wb_dreg, wb_data, wb_we, rs_addr, rt_addr, rs_use, rt_use,
           iss_we, iss_dreg, cancel_we, cancel_dreg,
    output rs_data, rt_data, stall, sb_err
  );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// 2**ADDR_W x DATA_W register file with writeback bypass, plus per-register
// pending-write counters that raise stall on RAW hazards.
module wb_regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input logic clk,
  input logic rst_n,
  wb_regfile_scoreboard_if.slave bus
);

  localparam int NREG = 1 << ADDR_W;
  localparam int SW   = CNT_W + 2;
  localparam logic signed [SW-1:0] ONE     = SW'(1);
  localparam logic signed [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  logic [DATA_W-1:0]       regs    [NREG];
  logic [CNT_W-1:0]        cnt     [NREG];
  logic [CNT_W-1:0]        cnt_nxt [NREG];
  logic signed [SW-1:0]    net_rd  [NREG];
  logic [NREG-1:0]         busy;
  logic                    iss_eff;
  logic                    err_set;
  logic                    sb_err_q;

  assign bus.rs_data = (bus.rs_addr == '0) ? '0 :
                       (bus.wb_we && bus.wb_dreg == bus.rs_addr) ? bus.wb_data :
                       regs[bus.rs_addr];
  assign bus.rt_data = (bus.rt_addr == '0) ? '0 :
                       (bus.wb_we && bus.wb_dreg == bus.rt_addr) ? bus.wb_data :
                       regs[bus.rt_addr];

  // Count after this cycle's completions; a register whose last write lands now is ready.
  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) begin
      net_rd[r] = {2'b00, cnt[r]};
      if (bus.wb_we && bus.wb_dreg == ADDR_W'(r))         net_rd[r] = net_rd[r] - ONE;
      if (bus.cancel_we && bus.cancel_dreg == ADDR_W'(r)) net_rd[r] = net_rd[r] - ONE;
      busy[r] = (r != 0) && (net_rd[r] != '0);
    end
  end

  assign bus.stall = (bus.rs_use & busy[bus.rs_addr]) | (bus.rt_use & busy[bus.rt_addr]);
  assign iss_eff   = bus.iss_we & ~bus.stall & (bus.iss_dreg != '0);

  always_comb begin
    logic signed [SW-1:0] nxt;
    nxt     = '0;
    err_set = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      nxt = net_rd[r];
      if (iss_eff && bus.iss_dreg == ADDR_W'(r)) nxt = nxt + ONE;
      cnt_nxt[r] = nxt[CNT_W-1:0];
      if (r == 0) begin
        cnt_nxt[r] = '0;
      end else if (nxt > CNT_MAX) begin
        cnt_nxt[r] = CNT_MAX[CNT_W-1:0];
        err_set    = 1'b1;
      end else if (nxt[SW-1]) begin
        cnt_nxt[r] = '0;
        err_set    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (bus.wb_we && bus.wb_dreg != '0) regs[bus.wb_dreg] <= bus.wb_data;
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      sb_err_q <= sb_err_q | err_set;
    end
  end

  assign bus.sb_err = sb_err_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed and randomized checks of the register file / scoreboard against
// an array-and-integer reference model.
module tb_wb_regfile_scoreboard;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 32;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_regs [NR];
  int            m_cnt  [NR];
  bit            m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.wb_we && bus.wb_dreg == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic int m_net(input int r);
    int n;
    n = m_cnt[r];
    if (bus.wb_we && int'(bus.wb_dreg) == r) n--;
    if (bus.cancel_we && int'(bus.cancel_dreg) == r) n--;
    return n;
  endfunction

  function automatic bit m_busy(input logic [AW-1:0] a);
    return (a != 0) && (m_net(int'(a)) != 0);
  endfunction

  function automatic bit m_stall();
    return (bus.rs_use && m_busy(bus.rs_addr)) || (bus.rt_use && m_busy(bus.rt_addr));
  endfunction

  task automatic m_clock();
    bit iss_eff;
    int n;
    iss_eff = bus.iss_we && !m_stall() && bus.iss_dreg != 0;
    for (int r = 1; r < NR; r++) begin
      n = m_net(r) + ((iss_eff && int'(bus.iss_dreg) == r) ? 1 : 0);
      if (n > CMAX) begin
        m_cnt[r] = CMAX;
        m_err    = 1'b1;
      end else if (n < 0) begin
        m_cnt[r] = 0;
        m_err    = 1'b1;
      end else begin
        m_cnt[r] = n;
      end
    end
    if (bus.wb_we && bus.wb_dreg != 0) m_regs[bus.wb_dreg] = bus.wb_data;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.wb_we = 0; bus.wb_dreg = '0; bus.wb_data = '0;
    bus.rs_addr = '0; bus.rt_addr = '0; bus.rs_use = 0; bus.rt_use = 0;
    bus.iss_we = 0; bus.iss_dreg = '0; bus.cancel_we = 0; bus.cancel_dreg = '0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic finish_cycle(input string tag);
    chk({tag, "_rs"},    bus.rs_data, m_read(bus.rs_addr));
    chk({tag, "_rt"},    bus.rt_data, m_read(bus.rt_addr));
    chk({tag, "_stall"}, {31'b0, bus.stall},  {31'b0, m_stall()});
    chk({tag, "_err"},   {31'b0, bus.sb_err}, {31'b0, m_err});
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic step(input string tag);
    settle();
    finish_cycle(tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence ----------------
  initial begin
    logic [DW-1:0] d7;
    m_reset();
    idle();
    rst_n = 1'b0;
    #12;
    bus.rs_addr = 5'd3; bus.rt_addr = 5'd9; bus.rs_use = 1; bus.rt_use = 1;
    #1;
    chk("rst_rs", bus.rs_data, 32'h0);
    chk("rst_rt", bus.rt_data, 32'h0);
    chk("rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("rst_err", {31'b0, bus.sb_err}, 32'h0);
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // bypass then array read
    bus.wb_we = 1; bus.wb_dreg = 5'd5; bus.wb_data = 32'hDEADBEEF;
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd5;
    settle();
    chk("byp_rs", bus.rs_data, 32'hDEADBEEF);
    chk("byp_rt", bus.rt_data, 32'hDEADBEEF);
    finish_cycle("byp");
    bus.wb_we = 0;
    settle();
    chk("arr_rs", bus.rs_data, 32'hDEADBEEF);
    chk("arr_rt", bus.rt_data, 32'hDEADBEEF);
    finish_cycle("arr");

    // register 0
    idle();
    bus.wb_we = 1; bus.wb_dreg = 5'd0; bus.wb_data = 32'h1234;
    bus.iss_we = 1; bus.iss_dreg = 5'd0; bus.rs_use = 1; bus.rt_use = 1;
    settle();
    chk("r0_rs", bus.rs_data, 32'h0);
    chk("r0_stall", {31'b0, bus.stall}, 32'h0);
    finish_cycle("r0");
    bus.wb_we = 0; bus.iss_we = 0;
    settle();
    chk("r0_rs2", bus.rs_data, 32'h0);
    chk("r0_stall2", {31'b0, bus.stall}, 32'h0);
    finish_cycle("r0b");

    // RAW on r7
    idle();
    bus.iss_we = 1; bus.iss_dreg = 5'd7;
    step("raw_iss");
    bus.iss_we = 0; bus.rs_addr = 5'd7; bus.rs_use = 1;
    settle();
    chk("raw_stall1", {31'b0, bus.stall}, 32'h1);
    finish_cycle("raw1");
    settle();
    chk("raw_stall2", {31'b0, bus.stall}, 32'h1);
    finish_cycle("raw2");
    d7 = $urandom;
    bus.wb_we = 1; bus.wb_dreg = 5'd7; bus.wb_data = d7;
    settle();
    chk("raw_wb_stall", {31'b0, bus.stall}, 32'h0);
    chk("raw_wb_rs", bus.rs_data, d7);
    finish_cycle("raw_wb");
    bus.wb_we = 0;
    settle();
    chk("raw_after", bus.rs_data, d7);
    finish_cycle("raw_after");

    // multi-flight on r3, overflow
    idle();
    bus.iss_we = 1; bus.iss_dreg = 5'd3;
    for (int i = 0; i < 3; i++) step("mf_iss");
    bus.iss_we = 0; bus.rs_addr = 5'd3; bus.rs_use = 1;
    settle();
    chk("mf_busy", {31'b0, bus.stall}, 32'h1);
    finish_cycle("mf_busy");
    bus.rs_use = 0; bus.iss_we = 1;
    step("mf_iss4");
    bus.iss_we = 0;
    settle();
    chk("mf_ovf_err", {31'b0, bus.sb_err}, 32'h1);
    finish_cycle("mf_ovf");
    bus.rs_use = 1; bus.wb_we = 1; bus.wb_dreg = 5'd3; bus.wb_data = 32'hA5A5_0003;
    settle();
    chk("mf_wb1_stall", {31'b0, bus.stall}, 32'h1);
    finish_cycle("mf_wb1");
    bus.cancel_we = 1; bus.cancel_dreg = 5'd3; bus.wb_data = 32'h5A5A_0003;
    settle();
    chk("mf_cwb_stall", {31'b0, bus.stall}, 32'h0);
    finish_cycle("mf_cwb");
    bus.wb_we = 0; bus.cancel_we = 0;
    settle();
    chk("mf_clear", {31'b0, bus.stall}, 32'h0);
    finish_cycle("mf_clear");

    // asynchronous reset mid-cycle
    idle();
    bus.rs_addr = 5'd5; bus.rt_addr = 5'd7;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_rs", bus.rs_data, 32'h0);
    chk("arst_rt", bus.rt_data, 32'h0);
    chk("arst_stall", {31'b0, bus.stall}, 32'h0);
    chk("arst_err", {31'b0, bus.sb_err}, 32'h0);
    m_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // simultaneous issue + writeback, then underflow
    idle();
    bus.iss_we = 1; bus.iss_dreg = 5'd9;
    step("sim_iss");
    bus.wb_we = 1; bus.wb_dreg = 5'd9; bus.wb_data = 32'h0000_0909;
    step("sim_both");
    idle();
    bus.rs_addr = 5'd9; bus.rs_use = 1;
    settle();
    chk("sim_cnt1", {31'b0, bus.stall}, 32'h1);
    finish_cycle("sim_cnt1");
    bus.wb_we = 1; bus.wb_dreg = 5'd9; bus.wb_data = 32'h0000_9999;
    step("sim_drain");
    idle();
    bus.rs_addr = 5'd9; bus.rs_use = 1;
    settle();
    chk("sim_empty", {31'b0, bus.stall}, 32'h0);
    chk("sim_noerr", {31'b0, bus.sb_err}, 32'h0);
    finish_cycle("sim_empty");
    bus.rs_use = 0; bus.wb_we = 1; bus.wb_dreg = 5'd4; bus.wb_data = 32'h0000_0444;
    step("udf");
    idle();
    bus.rt_addr = 5'd4; bus.rt_use = 1;
    settle();
    chk("udf_err", {31'b0, bus.sb_err}, 32'h1);
    chk("udf_stall", {31'b0, bus.stall}, 32'h0);
    chk("udf_data", bus.rt_data, 32'h0000_0444);
    finish_cycle("udf_after");

    // randomized traffic on a small register window
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      bus.rs_addr     = AW'($urandom_range(0, 7));
      bus.rt_addr     = AW'($urandom_range(0, 7));
      bus.rs_use      = ($urandom_range(0, 1) == 1);
      bus.rt_use      = ($urandom_range(0, 1) == 1);
      bus.iss_we      = ($urandom_range(0, 2) == 0);
      bus.iss_dreg    = AW'($urandom_range(0, 7));
      bus.wb_dreg     = AW'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      bus.wb_we       = ($urandom_range(0, 1) == 1) &&
                        (m_cnt[bus.wb_dreg] > 0 || $urandom_range(0, 15) == 0);
      bus.cancel_dreg = AW'($urandom_range(0, 7));
      bus.cancel_we   = ($urandom_range(0, 7) == 0) &&
                        (m_cnt[bus.cancel_dreg] > 0 || $urandom_range(0, 15) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
